// File: rtl/sample_mem_if.sv
// Avalon-MM pipelined-read bus between the sample fetch/writeback master and
// the memory responder, plus the responder's status outputs.
// Handshake: a request (read or write) is taken on a rising clk edge when it is
// asserted and waitrequest is low; each accepted read produces exactly one
// readdatavalid cycle later, in acceptance order, with no back-pressure on it.
interface sample_mem_if;
  logic [23:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [3:0]  outstanding;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic        proto_err;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, waitrequest,
    input  outstanding, rd_count, wr_count, proto_err
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, waitrequest,
    output outstanding, rd_count, wr_count, proto_err
  );
endinterface

// File: rtl/sample_mem_responder.sv
// Avalon-MM pipelined-read slave backed by on-chip word storage. Reads return
// after a fixed latency through an index shift pipeline; waitrequest throttles
// on the outstanding-read limit and on an optional periodic stall.
module sample_mem_responder #(
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 8,
  parameter int WAIT_EVERY   = 0
) (
  input  logic        clk,
  input  logic        reset,
  sample_mem_if.slave bus
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PIPE_D = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam int SW     = (WAIT_EVERY > 1) ? $clog2(WAIT_EVERY) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((WAIT_EVERY > 0) ? WAIT_EVERY - 1 : 0);

  logic [31:0]           r_mem [DEPTH];
  logic [PIPE_D-1:0]     r_vld_pipe;
  logic [DEPTH_LOG2-1:0] r_idx_pipe [PIPE_D];
  logic                  r_rdv;
  logic [31:0]           r_rdata;
  logic [3:0]            r_outstanding;
  logic [31:0]           r_rd_count;
  logic [31:0]           r_wr_count;
  logic                  r_proto_err;
  logic [SW-1:0]         r_stall_cnt;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [4:0]            w_pend_net;
  logic                  w_full;
  logic                  w_stall;
  logic                  w_wait;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_proto;
  logic                  w_last_vld;
  logic [DEPTH_LOG2-1:0] w_last_idx;
  logic                  w_unused_addr;

  // Byte address to word index; byte lane and upper bits alias away.
  assign w_idx         = bus.address[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{bus.address[23:DEPTH_LOG2+2], bus.address[1:0]};

  // Reads still owed after this cycle's return; a return frees its slot now.
  assign w_pend_net = {1'b0, r_outstanding} - {4'd0, r_rdv};
  assign w_full     = (w_pend_net >= 5'(MAX_PENDING));
  assign w_stall    = (WAIT_EVERY != 0) && (r_stall_cnt == STALL_LAST);
  assign w_wait     = reset | w_full | w_stall;

  // A write always wins; a read collides with a write and is dropped.
  assign w_acc_wr = bus.write & ~w_wait;
  assign w_acc_rd = bus.read & ~bus.write & ~w_wait;
  assign w_proto  = bus.read & bus.write & ~w_wait;

  // Stage that feeds the return register, collapsing the pipe at latency 1.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign w_last_vld = w_acc_rd;
      assign w_last_idx = w_idx;
    end else begin : g_latn
      assign w_last_vld = r_vld_pipe[PIPE_D-1];
      assign w_last_idx = r_idx_pipe[PIPE_D-1];
    end
  endgenerate

  // Word storage: written on accepted writes, never cleared by reset.
  always_ff @(posedge clk) begin
    if (w_acc_wr) r_mem[w_idx] <= bus.writedata;
  end

  // Read valid pipeline; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_acc_rd;
      for (int i = 1; i < PIPE_D; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  // Read index pipeline travelling alongside the valid bits.
  always_ff @(posedge clk) begin
    r_idx_pipe[0] <= w_idx;
    for (int i = 1; i < PIPE_D; i++) r_idx_pipe[i] <= r_idx_pipe[i-1];
  end

  // Return register: fetch storage at the last stage, hold data between returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdv   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdv <= w_last_vld;
      if (w_last_vld) r_rdata <= r_mem[w_last_idx];
    end
  end

  // Outstanding-read tracker, access counters and sticky collision flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_rd_count    <= '0;
      r_wr_count    <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      case ({w_acc_rd, r_rdv})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_acc_rd) r_rd_count <= r_rd_count + 32'd1;
      if (w_acc_wr) r_wr_count <= r_wr_count + 32'd1;
      if (w_proto)  r_proto_err <= 1'b1;
    end
  end

  // Free-running stall counter that paces the injected waitrequest cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (WAIT_EVERY != 0) begin
      r_stall_cnt <= (r_stall_cnt == STALL_LAST) ? '0 : r_stall_cnt + SW'(1);
    end
  end

  assign bus.waitrequest   = w_wait;
  assign bus.readdata      = r_rdata;
  assign bus.readdatavalid = r_rdv;
  assign bus.outstanding   = r_outstanding;
  assign bus.rd_count      = r_rd_count;
  assign bus.wr_count      = r_wr_count;
  assign bus.proto_err     = r_proto_err;

endmodule

// File: tb/tb_sample_mem_responder.sv
// Bench for sample_mem_responder: three instances (defaults, MAX_PENDING=2,
// WAIT_EVERY=4) driven by directed sequences; expected read returns and their
// cycles go into per-instance queues that negedge monitors pop and compare.
module tb_sample_mem_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sample_mem_if a_if ();
  sample_mem_if b_if ();
  sample_mem_if c_if ();

  sample_mem_responder u_dut_a (.clk(clk), .reset(rst_a), .bus(a_if));
  sample_mem_responder #(.MAX_PENDING(2)) u_dut_b (.clk(clk), .reset(rst_b), .bus(b_if));
  sample_mem_responder #(.WAIT_EVERY(4)) u_dut_c (.clk(clk), .reset(rst_c), .bus(c_if));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;

  logic [31:0] exp_q_a[$], exp_q_b[$], exp_q_c[$];
  int          exp_t_a[$], exp_t_b[$], exp_t_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitors: every readdatavalid must match the oldest expected return.
  always @(negedge clk) begin
    if (a_if.readdatavalid === 1'b1) begin
      if (exp_q_a.size() == 0) check("a_unexpected_rdv", {31'd0, a_if.readdatavalid}, 32'd0);
      else begin
        check("a_rdata", a_if.readdata, exp_q_a.pop_front());
        check("a_rdv_cycle", cyc, exp_t_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (b_if.readdatavalid === 1'b1) begin
      if (exp_q_b.size() == 0) check("b_unexpected_rdv", {31'd0, b_if.readdatavalid}, 32'd0);
      else begin
        check("b_rdata", b_if.readdata, exp_q_b.pop_front());
        check("b_rdv_cycle", cyc, exp_t_b.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (c_if.readdatavalid === 1'b1) begin
      if (exp_q_c.size() == 0) check("c_unexpected_rdv", {31'd0, c_if.readdatavalid}, 32'd0);
      else begin
        check("c_rdata", c_if.readdata, exp_q_c.pop_front());
        check("c_rdv_cycle", cyc, exp_t_c.pop_front());
      end
    end
  end

  // ---------------- driver tasks (instance a) ----------------
  task automatic req_a(input logic rd, input logic wr, input logic [23:0] addr,
                       input logic [31:0] wd, input bit push, input logic [31:0] exp,
                       output int acc);
    int budget;
    budget = 0;
    acc = -1;
    a_if.read = rd; a_if.write = wr; a_if.address = addr; a_if.writedata = wd;
    while (acc < 0 && budget < 50) begin
      @(negedge clk);
      if (!a_if.waitrequest) begin
        acc = cyc;
        if (push) begin
          exp_q_a.push_back(exp);
          exp_t_a.push_back(cyc + 3);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    a_if.read = 1'b0; a_if.write = 1'b0;
    if (acc < 0) check("a_accept", {31'd0, a_if.waitrequest}, 32'd0);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && exp_q_a.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- instance a: tests 1, 2, 4, 5, 6 ----------------
  initial begin
    int acc, prev;
    rst_a = 1'b1;
    a_if.read = 1'b0; a_if.write = 1'b0; a_if.address = '0; a_if.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitrequest", {31'd0, a_if.waitrequest}, 32'd1);
    check("rst_readdatavalid", {31'd0, a_if.readdatavalid}, 32'd0);
    check("rst_readdata", a_if.readdata, 32'd0);
    check("rst_outstanding", {28'd0, a_if.outstanding}, 32'd0);
    check("rst_rd_count", a_if.rd_count, 32'd0);
    check("rst_wr_count", a_if.wr_count, 32'd0);
    check("rst_proto_err", {31'd0, a_if.proto_err}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;

    // Test 1: write then read, return exactly 3 cycles after acceptance.
    req_a(1'b0, 1'b1, 24'h000010, 32'h12345678, 1'b0, 32'h0, acc);
    req_a(1'b1, 1'b0, 24'h000010, 32'h0, 1'b1, 32'h12345678, acc);
    drain_a();
    check("t1_rd_count", a_if.rd_count, 32'd1);
    check("t1_wr_count", a_if.wr_count, 32'd1);

    // Test 2: preload 0xA0..0xA7, 8 back-to-back reads never stalled.
    for (int i = 0; i < 8; i++)
      req_a(1'b0, 1'b1, 24'(i * 4), 32'h0A0 + 32'(i), 1'b0, 32'h0, acc);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      req_a(1'b1, 1'b0, 24'(i * 4), 32'h0, 1'b1, 32'h0A0 + 32'(i), acc);
      if (i > 0) check("t2_b2b_accept", 32'(acc - prev), 32'd1);
      prev = acc;
    end
    drain_a();

    // Test 4: aliasing of upper bits and byte lane.
    req_a(1'b0, 1'b1, 24'h000000, 32'hAAAA0000, 1'b0, 32'h0, acc);
    req_a(1'b1, 1'b0, 24'h001000, 32'h0, 1'b1, 32'hAAAA0000, acc);
    req_a(1'b1, 1'b0, 24'h000003, 32'h0, 1'b1, 32'hAAAA0000, acc);
    drain_a();

    // Test 5: read+write collision: write kept, read dropped, sticky error.
    req_a(1'b1, 1'b1, 24'h000020, 32'h00000055, 1'b0, 32'h0, acc);
    repeat (5) @(posedge clk); #1;
    check("t5_proto_err", {31'd0, a_if.proto_err}, 32'd1);
    req_a(1'b1, 1'b0, 24'h000020, 32'h0, 1'b1, 32'h00000055, acc);
    drain_a();
    check("t5_proto_err_sticky", {31'd0, a_if.proto_err}, 32'd1);
    check("t5_rd_count", a_if.rd_count, 32'd12);
    check("t5_wr_count", a_if.wr_count, 32'd11);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check("t5_proto_err_cleared", {31'd0, a_if.proto_err}, 32'd0);

    // Test 6: reset one cycle after the second accept flushes both reads.
    req_a(1'b1, 1'b0, 24'h000020, 32'h0, 1'b0, 32'h0, acc);
    req_a(1'b1, 1'b0, 24'h000020, 32'h0, 1'b0, 32'h0, acc);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    check("t6_outstanding", {28'd0, a_if.outstanding}, 32'd0);
    check("t6_rd_count", a_if.rd_count, 32'd0);
    check("t6_wr_count", a_if.wr_count, 32'd0);
    repeat (6) @(posedge clk); #1;
    req_a(1'b1, 1'b0, 24'h000020, 32'h0, 1'b1, 32'h00000055, acc);
    drain_a();
    check("t6_rd_count_after", a_if.rd_count, 32'd1);
    done_a = 1'b1;
  end

  // ---------------- instance b: test 3 (MAX_PENDING=2) ----------------
  initial begin
    logic [7:0] exp_wait;
    int n_acc;
    exp_wait = 8'b0010_0100;   // stalled at T2 and T5
    n_acc = 0;
    rst_b = 1'b1;
    b_if.read = 1'b0; b_if.write = 1'b0; b_if.address = '0; b_if.writedata = '0;
    repeat (3) @(posedge clk); #1;
    rst_b = 1'b0;
    b_if.write = 1'b1; b_if.writedata = 32'hB0B0B0B0;
    @(negedge clk);
    check("t3_preload_accept", {31'd0, b_if.waitrequest}, 32'd0);
    @(posedge clk); #1;
    b_if.write = 1'b0;
    b_if.read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_waitrequest", {31'd0, b_if.waitrequest}, {31'd0, exp_wait[k]});
      check("t3_outstanding_le2", {31'd0, (b_if.outstanding <= 4'd2)}, 32'd1);
      if (!b_if.waitrequest) begin
        exp_q_b.push_back(32'hB0B0B0B0);
        exp_t_b.push_back(cyc + 3);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    b_if.read = 1'b0;
    check("t3_accepts", 32'(n_acc), 32'd6);
    for (int i = 0; i < 40 && exp_q_b.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    check("t3_outstanding_end", {28'd0, b_if.outstanding}, 32'd0);
    done_b = 1'b1;
  end

  // ---------------- instance c: test 7 (WAIT_EVERY=4) ----------------
  initial begin
    int n_acc;
    bit taken;
    rst_c = 1'b1;
    c_if.read = 1'b0; c_if.write = 1'b0; c_if.address = '0; c_if.writedata = '0;
    repeat (3) @(posedge clk); #1;
    rst_c = 1'b0;
    for (int i = 0; i < 12; i++) begin
      c_if.write = 1'b1; c_if.address = 24'(i * 4); c_if.writedata = 32'h0C0 + 32'(i);
      taken = 1'b0;
      for (int b = 0; b < 10 && !taken; b++) begin
        @(negedge clk);
        taken = !c_if.waitrequest;
        @(posedge clk); #1;
      end
      if (!taken) check("t7_preload_accept", {31'd0, c_if.waitrequest}, 32'd0);
    end
    c_if.write = 1'b0;
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    n_acc = 0;
    c_if.read = 1'b1;
    c_if.address = 24'h0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("t7_waitrequest", {31'd0, c_if.waitrequest}, {31'd0, (k % 4 == 3)});
      if (!c_if.waitrequest) begin
        exp_q_c.push_back(32'h0C0 + 32'(n_acc));
        exp_t_c.push_back(cyc + 3);
        n_acc++;
      end
      @(posedge clk); #1;
      c_if.address = 24'(n_acc * 4);
    end
    c_if.read = 1'b0;
    check("t7_accepts", 32'(n_acc), 32'd12);
    for (int i = 0; i < 40 && exp_q_c.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk); #1;
    check("t7_rd_count", c_if.rd_count, 32'd12);
    done_c = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    for (int i = 0; i < 5000 && !(done_a && done_b && done_c); i++) @(posedge clk);
    check("all_sequences_done", {29'd0, done_a, done_b, done_c}, 32'd7);
    check("a_queue_empty", 32'(exp_q_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_q_b.size()), 32'd0);
    check("c_queue_empty", 32'(exp_q_c.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
